// File: rtl/sar_adc_ctrl_pkg.sv
// Shared types and helpers for the SAR ADC controller: FSM state encoding,
// parameter lower bounds and the 2-of-3 majority vote.
package adc_pkg;

  localparam int SETTLE_MIN     = 5;
  localparam int SAMPLE_DIV_MIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIAL,
    ST_SETTLE,
    ST_DECIDE,
    ST_DONE
  } sar_state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_sync2.sv
// Two-flop synchronizer with synchronous active-high reset, used for the
// asynchronous comparator input.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample-tick divider, binary-search FSM
// and DAC drive. Optional macro SAR_ADC_CMP_MAJORITY_EN adds 2-of-3 comparator voting.
module sar_adc_ctrl
  import adc_pkg::*;
#(
  parameter int RES        = 8,
  parameter int N          = 16,
  parameter int SETTLE     = 100,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmp,
  output logic [RES-1:0] dac,
  output logic [N-1:0]   Dout,
  output logic           EN,
  output logic           busy,
  output logic           overrun
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int KW = (RES > 1) ? $clog2(RES) : 1;

  if (SETTLE < SETTLE_MIN || SAMPLE_DIV < SAMPLE_DIV_MIN || N < RES) begin : g_param_check
    $error("sar_adc_ctrl: illegal parameter combination");
  end

  sar_state_t     state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic [RES-1:0] result_q, result_d;
  logic [RES-1:0] dac_q, dac_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           en_q, en_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;
  logic           tick;
  logic           cmp_s;
  logic           decision;

  sync2 u_cmp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cmp),
    .q     (cmp_s)
  );

`ifdef SAR_ADC_CMP_MAJORITY_EN
  // The window is already full of post-settle samples by the DECIDE cycle.
  logic [2:0] maj_q, maj_d;

  always_comb maj_d = {maj_q[1:0], cmp_s};

  always_ff @(posedge clk) begin
    if (reset) maj_q <= '0;
    else       maj_q <= maj_d;
  end

  assign decision = maj3(maj_q);
`else
  assign decision = cmp_s;
`endif

  assign tick = (div_q == DW'(SAMPLE_DIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    cnt_d     = cnt_q;
    k_d       = k_q;
    result_d  = result_q;
    dac_d     = dac_q;
    dout_d    = dout_q;
    en_d      = 1'b0;
    overrun_d = overrun_q | (tick && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          result_d = '0;
          k_d      = KW'(RES - 1);
          state_d  = ST_TRIAL;
        end
      end
      ST_TRIAL: begin
        dac_d   = result_q | (RES'(1) << k_q);
        cnt_d   = CW'(SETTLE - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_DECIDE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DECIDE: begin
        result_d[k_q] = decision;
        if (k_q == '0) begin
          dout_d  = N'(result_d);
          en_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q - 1'b1;
          state_d = ST_TRIAL;
        end
      end
      ST_DONE: begin
        dac_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      result_q  <= '0;
      dac_q     <= '0;
      dout_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      result_q  <= result_d;
      dac_q     <= dac_d;
      dout_q    <= dout_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign dac     = dac_q;
  assign Dout    = dout_q;
  assign EN      = en_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
